// File: rtl/mul_man_pipe.sv
// Two-stage pipelined unsigned mantissa multiplier with truncate / round-nearest-even.
// Stage 1 holds two partial products; stage 2 sums them and rounds to OUT_W bits.
// Valid/ready handshake on both sides; capacity of two results in flight.
module mul_man_pipe #(
    parameter int MAN_W = 12,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] op1,
    input  logic [MAN_W-1:0] op2,
    input  logic             rnd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             inexact
);
    localparam int SPLIT = MAN_W / 2;
    localparam int HI_W  = MAN_W - SPLIT;
    localparam int LO_W  = MAN_W + SPLIT;
    localparam int HP_W  = MAN_W + HI_W;
    localparam int PW    = 2 * MAN_W;
    localparam int D     = PW - OUT_W;

    // stage 1 state
    logic            r_v1;
    logic [LO_W-1:0] r_lo;
    logic [HP_W-1:0] r_hi;
    logic            r_m1;
    // stage 2 state
    logic             r_v2;
    logic [OUT_W-1:0] r_res;
    logic             r_inx;

    logic             w_ld1, w_ld2;
    logic [LO_W-1:0]  w_lo;
    logic [HP_W-1:0]  w_hi;
    logic [PW-1:0]    w_p;
    logic [OUT_W-1:0] w_res;
    logic             w_inx;

    // Stage 2 advances when empty or drained; stage 1 when empty or stage 2 advances.
    // in_ready depends only on state, out_ready, rst and flush (never on in_valid).
    assign w_ld2    = !r_v2 || out_ready;
    assign w_ld1    = !r_v1 || w_ld2;
    assign in_ready = !rst && !flush && w_ld1;

    // Partial products over the low and high halves of op2.
    assign w_lo = LO_W'(op1) * LO_W'(op2[SPLIT-1:0]);
    assign w_hi = HP_W'(op1) * HP_W'(op2[MAN_W-1:SPLIT]);

    // Exact full product recombined from the registered partials.
    assign w_p = PW'(r_lo) + (PW'(r_hi) << SPLIT);

    generate
        if (D == 0) begin : g_exact
            assign w_res = w_p;
            assign w_inx = 1'b0;
        end else begin : g_round
            logic [OUT_W-1:0] w_trunc;
            logic             w_g, w_s, w_up;
            assign w_trunc = w_p[PW-1:D];
            assign w_g     = w_p[D-1];
            if (D >= 2) begin : g_sticky
                assign w_s = |w_p[D-2:0];
            end else begin : g_nosticky
                assign w_s = 1'b0;
            end
            // RNE increment: guard set and either sticky or odd LSB. The legal
            // OUT_W range keeps the all-ones truncation from ever seeing G=1.
            assign w_up  = r_m1 && w_g && (w_s || w_trunc[0]);
            assign w_inx = w_g || w_s;
            assign w_res = w_trunc + OUT_W'(w_up);
        end
    endgenerate

    // Stage 1: capture partial products and mode with the operand pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_lo <= '0;
            r_hi <= '0;
            r_m1 <= 1'b0;
        end else begin
            if (flush)      r_v1 <= 1'b0;
            else if (w_ld1) r_v1 <= in_valid;
            if (w_ld1 && in_valid) begin
                r_lo <= w_lo;
                r_hi <= w_hi;
                r_m1 <= rnd_mode;
            end
        end
    end

    // Stage 2: capture the rounded result; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2  <= 1'b0;
            r_res <= '0;
            r_inx <= 1'b0;
        end else begin
            if (flush)      r_v2 <= 1'b0;
            else if (w_ld2) r_v2 <= r_v1;
            if (w_ld2 && r_v1) begin
                r_res <= w_res;
                r_inx <= w_inx;
            end
        end
    end

    assign out_valid = r_v2;
    assign result    = r_res;
    assign inexact   = r_inx;

endmodule

// File: tb/tb_mul_man_pipe.sv
// Scoreboard bench for mul_man_pipe (MAN_W=12, OUT_W=16).
module tb_mul_man_pipe;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, rnd_mode, out_valid, out_ready, inexact;
    logic [11:0] op1, op2;
    logic [15:0] result;

    mul_man_pipe #(.MAN_W(12), .OUT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .rnd_mode(rnd_mode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .inexact(inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        inx;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0, cyc = 0;
    bit          acc, cons, lat_en;
    logic [15:0] cur_res;
    logic        cur_inx;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h @cyc %0d", tag, act, exp, cyc);
        end
    endtask

    // Reference: full 24-bit product, keep top 16, RNE on the 8 dropped bits.
    function automatic logic [16:0] model(input logic [11:0] a, input logic [11:0] b, input logic m);
        logic [23:0] p;
        logic [15:0] t;
        logic        g, s;
        p = 24'(a) * 24'(b);
        t = p[23:8];
        g = p[7];
        s = |p[6:0];
        if (m && g && (s || t[0])) t = t + 16'd1;
        return {(g || s), t};
    endfunction

    // One clock: observe handshakes just before the edge, then advance.
    task automatic tick();
        exp_t e;
        #1;
        acc  = in_valid && in_ready;
        cons = out_valid && out_ready;
        if (cons) begin
            if (q.size() == 0) chk("spurious_out", 32'(result), 32'hDEAD);
            else begin
                e = q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("inexact", 32'(inexact), 32'(e.inx));
                if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
            end
        end
        if (acc) q.push_back('{res: cur_res, inx: cur_inx, acc: cyc, lat: lat_en});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_exp(input logic [11:0] a, input logic [11:0] b, input logic m,
                             input logic [15:0] er, input logic ei);
        int c;
        in_valid = 1'b1; op1 = a; op2 = b; rnd_mode = m;
        cur_res = er; cur_inx = ei;
        c = 0;
        do begin
            tick();
            c++;
        end while (!acc && c < 40);
        if (!acc) chk("accept_timeout", 32'(c), 32'd0);
    endtask

    task automatic drive(input logic [11:0] a, input logic [11:0] b, input logic m);
        logic [16:0] r;
        r = model(a, b, m);
        drive_exp(a, b, m, r[15:0], r[16]);
    endtask

    task automatic drain(input int budget);
        int c;
        in_valid = 1'b0;
        c = 0;
        while (q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [11:0] sa[5], sb[5];
        logic        sm[5];
        logic [16:0] r;
        logic [15:0] hold;
        bit          seen;
        int          idx, c;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op1 = '0; op2 = '0; rnd_mode = 1'b0; lat_en = 1'b0;
        cur_res = '0; cur_inx = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_inexact", 32'(inexact), 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_ready", 32'(in_ready), 32'd1);

        // directed corner values, issued back to back
        lat_en = 1'b1;
        drive_exp(12'hFFF, 12'hFFF, 1'b0, 16'hFFE0, 1'b1);
        drive_exp(12'hFFF, 12'hFFF, 1'b1, 16'hFFE0, 1'b1);
        drive_exp(12'h003, 12'h080, 1'b1, 16'h0002, 1'b1);
        drive_exp(12'h001, 12'h080, 1'b1, 16'h0000, 1'b1);
        drive_exp(12'h003, 12'h080, 1'b0, 16'h0001, 1'b1);
        drive_exp(12'h001, 12'h080, 1'b0, 16'h0000, 1'b1);
        drive_exp(12'h100, 12'h100, 1'b1, 16'h0100, 1'b0);
        drain(20);

        // four back-to-back inputs with alternating modes
        for (int i = 0; i < 4; i++)
            drive(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), i[0]);
        drain(20);

        // stall: consumer blocked while five inputs are offered
        lat_en = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sa[i] = 12'($urandom_range(0, 4095));
            sb[i] = 12'($urandom_range(0, 4095));
            sm[i] = 1'($urandom_range(0, 1));
        end
        idx = 0; seen = 1'b0; hold = '0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; op1 = sa[idx]; op2 = sb[idx]; rnd_mode = sm[idx];
            r = model(sa[idx], sb[idx], sm[idx]);
            cur_res = r[15:0]; cur_inx = r[16];
            tick();
            if (acc) idx++;
            if (out_valid) begin
                if (!seen) begin seen = 1'b1; hold = result; end
                else chk("stall_hold", 32'(result), 32'(hold));
            end
        end
        chk("stall_accepts", 32'(idx), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        c = 0;
        while (idx < 5 && c < 40) begin
            in_valid = 1'b1; op1 = sa[idx]; op2 = sb[idx]; rnd_mode = sm[idx];
            r = model(sa[idx], sb[idx], sm[idx]);
            cur_res = r[15:0]; cur_inx = r[16];
            tick();
            if (acc) idx++;
            c++;
        end
        chk("stall_all_accepted", 32'(idx), 32'd5);
        drain(20);

        // flush with two in flight
        out_ready = 1'b0;
        drive(12'h123, 12'h456, 1'b1);
        drive(12'hABC, 12'h0DE, 1'b0);
        flush = 1'b1; in_valid = 1'b1; op1 = 12'h777; op2 = 12'h777;
        #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_no_emit", 32'(out_valid), 32'd0);
        end
        lat_en = 1'b1;
        drive(12'h9A5, 12'h3C7, 1'b1);
        drain(20);

        // reset mid-stream
        lat_en = 1'b0;
        drive(12'h5A5, 12'hA5A, 1'b1);
        drive(12'hFFF, 12'h001, 1'b0);
        in_valid = 1'b0;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1 chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_inexact", 32'(inexact), 32'd0);
        q.delete();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

        // random traffic with random back-pressure
        idx = 0; c = 0;
        in_valid = 1'b0;
        while (idx < 150 && c < 3000) begin
            if (!in_valid || acc) begin
                op1 = 12'($urandom_range(0, 4095));
                op2 = 12'($urandom_range(0, 4095));
                rnd_mode = 1'($urandom_range(0, 1));
                r = model(op1, op2, rnd_mode);
                cur_res = r[15:0]; cur_inx = r[16];
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc) idx++;
            c++;
        end
        chk("rand_all_accepted", 32'(idx), 32'd150);
        out_ready = 1'b1;
        drain(40);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
